// File: rtl/serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// serial_sub_ctrl
//
// Bit-serial subtraction controller. Computes (a - b - bin) mod 2^WIDTH by
// pushing one operand bit per cycle, LSB first, through a single 1-bit
// full_subtractor cell. The borrow is kept in a register between cycles.
// This is the area-minimal sequential alternative to a WIDTH-bit ripple
// subtractor, and it uses a start/busy/done handshake.
//
// Optional feature macro: SERIAL_SUB_FLAGS_EN
//   When defined, adds the registered result flags 'zero' and 'eq'.
//
// Parameters
//   WIDTH  operand/result width in bits (2..32), default 8
//
// Ports
//   clk    in   clock, all state updates on the rising edge
//   rst    in   synchronous active-high reset
//   start  in   request a subtraction, only looked at in IDLE
//   a      in   minuend, captured when start is accepted
//   b      in   subtrahend, captured when start is accepted
//   bin    in   borrow-in, captured when start is accepted
//   busy   out  high while bits are being processed (SHIFT)
//   done   out  one-cycle pulse while diff/bout hold a fresh result
//   diff   out  registered difference, held until next completion/reset
//   bout   out  registered final borrow, high iff a < b + bin
//   zero   out  (SERIAL_SUB_FLAGS_EN) result is all zeros
//   eq     out  (SERIAL_SUB_FLAGS_EN) a == b (zero, no borrow, bin was 0)
// ---------------------------------------------------------------------------

// One-bit full subtractor: d = x - y - bi, bo = borrow out of this bit.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             eq
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    logic             fs_d;
    logic             fs_bo;

`ifdef SERIAL_SUB_FLAGS_EN
    logic             zacc;
    logic             bin_cap;
`endif

    // The single arithmetic cell sees the operand LSBs and the held borrow.
    full_subtractor u_fs (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .bi (borrow),
        .d  (fs_d),
        .bo (fs_bo)
    );

    assign last_bit = (cnt == LAST_BIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs. busy/done decode straight from the
    // state register, so they can never be high together.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, per-bit shifting and the result registers.
    // The counter is held on the last bit rather than incremented, so it
    // never wraps when WIDTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        res_sr <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    borrow <= fs_bo;
                    res_sr <= {fs_d, res_sr[WIDTH-1:1]};
                    if (last_bit) begin
                        diff <= {fs_d, res_sr[WIDTH-1:1]};
                        bout <= fs_bo;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_FLAGS_EN
    // Result flags. The zero test is built serially by OR-ing each diff bit
    // as it is produced; the captured borrow-in is kept separately because
    // the borrow register is overwritten during SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            zacc    <= 1'b0;
            bin_cap <= 1'b0;
            zero    <= 1'b0;
            eq      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        zacc    <= 1'b0;
                        bin_cap <= bin;
                    end
                end
                SHIFT: begin
                    zacc <= zacc | fs_d;
                    if (last_bit) begin
                        zero <= ~(zacc | fs_d);
                        eq   <= ~(zacc | fs_d) & ~fs_bo & ~bin_cap;
                    end
                end
                default: begin
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_sub_ctrl
//
// Self-checking bench for serial_sub_ctrl. Two instances run side by side:
// WIDTH=8 for directed vectors plus a random sweep, and WIDTH=13 for a
// second random sweep. Drivers push the expected result into a per-instance
// queue when a start is issued; monitors pop and compare on every done.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_serial_sub_ctrl;

    localparam int W8  = 8;
    localparam int W13 = 13;

    logic clk = 1'b0;

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    logic           rst8, start8, bin8, busy8, done8, bout8;
    logic [W8-1:0]  a8, b8, diff8;
    logic           rst13, start13, bin13, busy13, done13, bout13;
    logic [W13-1:0] a13, b13, diff13;
`ifdef SERIAL_SUB_FLAGS_EN
    logic           zero8, eq8, zero13, eq13;
`endif

    serial_sub_ctrl #(.WIDTH(W8)) u_dut8 (
        .clk   (clk),
        .rst   (rst8),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8)
`ifdef SERIAL_SUB_FLAGS_EN
        ,
        .zero  (zero8),
        .eq    (eq8)
`endif
    );

    serial_sub_ctrl #(.WIDTH(W13)) u_dut13 (
        .clk   (clk),
        .rst   (rst13),
        .start (start13),
        .a     (a13),
        .b     (b13),
        .bin   (bin13),
        .busy  (busy13),
        .done  (done13),
        .diff  (diff13),
        .bout  (bout13)
`ifdef SERIAL_SUB_FLAGS_EN
        ,
        .zero  (zero13),
        .eq    (eq13)
`endif
    );

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic        z;
        logic        e;
    } exp_t;

    exp_t q8[$];
    exp_t q13[$];
    exp_t m8;
    exp_t m13;
    int   nChecks = 0;
    int   nFails  = 0;
    logic fin13   = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, req, $time);
        end
    endtask

    // Reference for the random sweeps: plain integer subtraction.
    function automatic exp_t refModel(input int unsigned a, input int unsigned b,
                                      input int unsigned bin, input int w);
        exp_t   e;
        longint mask;
        longint r;
        mask = (longint'(1) << w) - 1;
        r    = longint'(a) - longint'(b) - longint'(bin);
        e.d  = 32'(r & mask);
        e.bo = (longint'(a) < longint'(b) + longint'(bin));
        e.z  = (e.d == 32'd0);
        e.e  = (a == b) && (bin == 0);
        return e;
    endfunction

    // Monitor for the 8-bit instance: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            checkOutput("busy8_with_done", 32'(busy8), 32'd0);
            checkOutput("done8_expected", 32'(q8.size() > 0), 32'd1);
            if (q8.size() > 0) begin
                m8 = q8.pop_front();
                checkOutput("diff8", 32'(diff8), m8.d);
                checkOutput("bout8", 32'(bout8), 32'(m8.bo));
`ifdef SERIAL_SUB_FLAGS_EN
                checkOutput("zero8", 32'(zero8), 32'(m8.z));
                checkOutput("eq8", 32'(eq8), 32'(m8.e));
`endif
            end
        end
    end

    // Monitor for the 13-bit instance.
    always @(negedge clk) begin
        if (done13 === 1'b1) begin
            checkOutput("busy13_with_done", 32'(busy13), 32'd0);
            checkOutput("done13_expected", 32'(q13.size() > 0), 32'd1);
            if (q13.size() > 0) begin
                m13 = q13.pop_front();
                checkOutput("diff13", 32'(diff13), m13.d);
                checkOutput("bout13", 32'(bout13), 32'(m13.bo));
`ifdef SERIAL_SUB_FLAGS_EN
                checkOutput("zero13", 32'(zero13), 32'(m13.z));
                checkOutput("eq13", 32'(eq13), 32'(m13.e));
`endif
            end
        end
    end

    // Issue one operation on the 8-bit instance and wait for its done.
    // Inputs are scrambled right after acceptance to prove they are captured.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic bin, input logic [7:0] expD,
                                 input logic expBo, input logic expZ,
                                 input logic expE, output int lat,
                                 output int busyCnt);
        exp_t e;
        @(negedge clk);
        a8     = a;
        b8     = b;
        bin8   = bin;
        start8 = 1'b1;
        e.d    = 32'(expD);
        e.bo   = expBo;
        e.z    = expZ;
        e.e    = expE;
        q8.push_back(e);
        @(posedge clk);
        #1;
        start8  = 1'b0;
        a8      = ~a;
        b8      = ~b;
        bin8    = ~bin;
        lat     = 0;
        busyCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (busy8) busyCnt++;
            if (done8) break;
        end
        checkOutput("done8_seen", 32'(done8), 32'd1);
    endtask

    // Main 8-bit sequence.
    initial begin
        int   lat;
        int   bc;
        int   nDone;
        int   donePos[3];
        exp_t e;

        rst8   = 1'b1;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        bin8   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy8), 32'd0);
        checkOutput("rst_done", 32'(done8), 32'd0);
        checkOutput("rst_diff", 32'(diff8), 32'd0);
        checkOutput("rst_bout", 32'(bout8), 32'd0);
`ifdef SERIAL_SUB_FLAGS_EN
        checkOutput("rst_zero", 32'(zero8), 32'd0);
        checkOutput("rst_eq", 32'(eq8), 32'd0);
`endif
        rst8 = 1'b0;

        applyStimulus(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, lat, bc);
        checkOutput("latency", 32'(lat), 32'd9);
        checkOutput("busy_cycles", 32'(bc), 32'd8);
        applyStimulus(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, lat, bc);
        applyStimulus(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, lat, bc);
        applyStimulus(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, lat, bc);
        applyStimulus(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, lat, bc);
        applyStimulus(8'h01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, lat, bc);

        // Start held high while operands change every cycle. Accepts land on
        // edges 0, 10 and 20; dones are seen at negedges 9, 19 and 29.
        e = '{d: 32'h3C, bo: 1'b1, z: 1'b0, e: 1'b0};
        q8.push_back(e);
        e = '{d: 32'h20, bo: 1'b0, z: 1'b0, e: 1'b0};
        q8.push_back(e);
        e = '{d: 32'h04, bo: 1'b0, z: 1'b0, e: 1'b0};
        q8.push_back(e);
        nDone = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (done8) begin
                if (nDone < 3) donePos[nDone] = k;
                nDone++;
            end
            start8 = (k < 30);
            a8     = 8'(k * 37 + 5);
            b8     = 8'(k * 91 + 200);
            bin8   = (k % 5 == 0);
        end
        start8 = 1'b0;
        checkOutput("hold_done_count", 32'(nDone), 32'd3);
        checkOutput("hold_done_pos0", 32'(donePos[0]), 32'd9);
        checkOutput("hold_done_pos1", 32'(donePos[1]), 32'd19);
        checkOutput("hold_done_pos2", 32'(donePos[2]), 32'd29);

        // Reset asserted during the 4th SHIFT cycle aborts the operation.
        @(negedge clk);
        a8     = 8'h5A;
        b8     = 8'h33;
        bin8   = 1'b0;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy8), 32'd0);
        checkOutput("abort_done", 32'(done8), 32'd0);
        checkOutput("abort_diff", 32'(diff8), 32'd0);
        checkOutput("abort_bout", 32'(bout8), 32'd0);
        rst8  = 1'b0;
        nDone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) nDone++;
        end
        checkOutput("abort_no_done", 32'(nDone), 32'd0);
        applyStimulus(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, lat, bc);

        // Random sweep at WIDTH=8.
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra, rb;
            logic       rbin;
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom_range(0, 1));
            e    = refModel(ra, rb, rbin, W8);
            applyStimulus(ra, rb, rbin, e.d[7:0], e.bo, e.z, e.e, lat, bc);
        end

        for (int i = 0; i < 50000 && !fin13; i++) @(negedge clk);
        checkOutput("sweep13_finished", 32'(fin13), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("q8_drained", 32'(q8.size()), 32'd0);
        checkOutput("q13_drained", 32'(q13.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

    // Random sweep at WIDTH=13, running alongside the 8-bit sequence.
    initial begin
        exp_t e;
        rst13   = 1'b1;
        start13 = 1'b0;
        a13     = '0;
        b13     = '0;
        bin13   = 1'b0;
        repeat (3) @(negedge clk);
        rst13 = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a13     = 13'($urandom);
            b13     = 13'($urandom);
            bin13   = 1'($urandom_range(0, 1));
            start13 = 1'b1;
            e       = refModel(a13, b13, bin13, W13);
            q13.push_back(e);
            @(posedge clk);
            #1;
            start13 = 1'b0;
            a13     = ~a13;
            b13     = ~b13;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done13) break;
            end
            checkOutput("done13_seen", 32'(done13), 32'd1);
        end
        fin13 = 1'b1;
    end

    // Hard stop in case something upstream never returns.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtraction controller. It computes `a - b - bin` on WIDTH-bit operands by pushing one bit per cycle, LSB first, through a single instance of the team's 1-bit `full_subtractor` cell. The borrow is held in a register between cycles. The block sits alongside the combinational arithmetic cells as the area-minimal sequential alternative to a WIDTH-bit ripple subtractor, and uses a start/busy/done handshake.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.
- `clk` input 1: clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a subtraction. Sampled only in IDLE.
- `a` input WIDTH: minuend. Captured when start is accepted.
- `b` input WIDTH: subtrahend. Captured when start is accepted.
- `bin` input 1: borrow-in. Captured when start is accepted.
- `busy` output 1: high while bits are being processed (SHIFT state).
- `done` output 1: single-cycle pulse when the result is valid.
- `diff` output WIDTH: difference, `(a - b - bin) mod 2^WIDTH`.
- `bout` output 1: final borrow-out. High iff `a < b + bin` (unsigned).

## Operation
- States and transitions:
  - IDLE → SHIFT on `start`.
  - SHIFT → SHIFT while bit counter < WIDTH-1.
  - SHIFT → DONE on the last bit.
  - DONE → IDLE unconditionally.
- On start acceptance in IDLE:
  - Operand shift registers load `a` and `b`.
  - Borrow register loads `bin`.
  - Bit counter clears to 0.
  - Result shift register is cleared.
- Each SHIFT cycle:
  - The full_subtractor receives the operand LSBs and the borrow register.
  - Its diff bit shifts into the result shift register MSB; the result register shifts right.
  - Its borrow-out loads the borrow register.
  - Operand registers shift right by 1; the counter increments.
- The bit counter is `$clog2(WIDTH)` bits wide and must not wrap before the DONE transition.
- On the SHIFT → DONE edge:
  - `diff` loads the completed result (bit 0 = first bit processed).
  - `bout` loads the final borrow.
- `diff` and `bout` are registered and hold their value until the next completion or reset.
- `start` is ignored in SHIFT and DONE. It is not queued.
- `a`, `b` and `bin` may change freely after acceptance; only the captured values are used.

## Timing
- Reset values:
  - state = IDLE.
  - busy = 0, done = 0, diff = 0, bout = 0.
  - Internal shift, borrow and counter registers = 0.
- Latency: start sampled at edge E0 → busy high from E0 through E(WIDTH).
- diff and bout are valid and done = 1 for exactly one cycle after E(WIDTH). Total WIDTH+1 cycles start-to-done.
- Throughput: a new start is accepted no earlier than the cycle after done (IDLE). Back-to-back issue costs WIDTH+2 cycles per operation.
- busy and done are never high together.
- Reset mid-operation: the operation is aborted, all outputs return to reset values on the next edge, and no done pulse is produced.
- If rst and start are both high, rst wins.

## Configuration
- `SERIAL_SUB_FLAGS_EN` defined: adds two registered outputs, updated on the same edge as diff/bout and reset to 0:
  - `zero` (1 bit): high iff the result is all zeros. Tracked serially by OR-accumulating diff bits during SHIFT; no wide reduction on the result.
  - `eq` (1 bit): high iff zero = 1 and bout = 0 with captured bin = 0, i.e. a == b.
- `SERIAL_SUB_FLAGS_EN` undefined: the ports and the accumulation logic are absent. Behaviour is otherwise identical.

## Test plan
- WIDTH=8: a=0x05, b=0x03, bin=0, pulse start → done after 9 cycles, diff=0x02, bout=0; busy high for exactly 8 cycles.
- a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1.
- a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=0 → diff=0x00, bout=0; with the macro, zero=1 and eq=1.
- Hold start high continuously and change a/b every cycle during SHIFT → only the first operands are used, one done per WIDTH+2 cycles, and results match the captured values.
- Assert rst on the 4th SHIFT cycle → next cycle busy=0, diff=0, bout=0, no done. A following start with a=0x80, b=0x01 → diff=0x7F, bout=0.
- Random sweep of 1000 operations at WIDTH=8 and WIDTH=13 → diff and bout match the `a - b - bin` reference model; done never overlaps busy.
